// File: rtl/mcht_link_arb.sv
// mcht_link_arb: round-robin sequencer sharing one Manchester transceiver among requesters.
module mcht_link_arb #(
  parameter int pNUM_REQ    = 4,
  parameter int pTX_MSG_LEN = 16,
  parameter int pRX_MSG_LEN = 16,
  parameter int pRSP_TMO    = 1024
) (
  input  logic                            CLK_25M,
  input  logic                            RST_N,
  input  logic [pNUM_REQ-1:0]             REQ_VLD,
  input  logic [pNUM_REQ*pTX_MSG_LEN-1:0] REQ_MSG,
  output logic [pNUM_REQ-1:0]             REQ_ACK,
  output logic [pNUM_REQ-1:0]             RSP_VLD,
  output logic [pNUM_REQ-1:0]             RSP_TO,
  output logic [pRX_MSG_LEN-1:0]          RSP_MSG,
  output logic                            BUSY,
  output logic                            ERR_UNSOL,
  output logic                            TX_VLD,
  output logic [pTX_MSG_LEN-1:0]          TX_MSG,
  input  logic                            TX_DNE,
  input  logic [pRX_MSG_LEN-1:0]          RX_MSG,
  input  logic                            RX_VLD
);
  localparam int PW = $clog2(pNUM_REQ);
  localparam int TW = $clog2(pRSP_TMO + 1);
  typedef enum logic [1:0] {IDLE, WAIT_DNE, WAIT_RSP} state_t;
  state_t state_q, state_d;
  logic [PW-1:0] ptr_q, ptr_d, gnt_q, gnt_d, pick;
  logic [PW:0] idx;
  logic hit;
  logic [TW-1:0] tmr_q, tmr_d;
  logic [pNUM_REQ-1:0] req_ack_q, req_ack_d, rsp_vld_q, rsp_vld_d, rsp_to_q, rsp_to_d;
  logic tx_vld_q, tx_vld_d, err_unsol_q, err_unsol_d;
  logic [pTX_MSG_LEN-1:0] tx_msg_q, tx_msg_d;
  logic [pRX_MSG_LEN-1:0] rsp_msg_q, rsp_msg_d;
  // Scan offsets from highest to lowest so the closest set bit at/after the pointer wins.
  always_comb begin
    pick = '0;
    hit  = 1'b0;
    idx  = '0;
    for (int k = pNUM_REQ - 1; k >= 0; k--) begin
      idx = {1'b0, ptr_q} + (PW+1)'(k);
      idx = (idx >= (PW+1)'(pNUM_REQ)) ? idx - (PW+1)'(pNUM_REQ) : idx;
      if (REQ_VLD[idx[PW-1:0]]) begin
        pick = idx[PW-1:0];
        hit  = 1'b1;
      end
    end
  end
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    gnt_d       = gnt_q;
    tmr_d       = tmr_q;
    req_ack_d   = '0;
    rsp_vld_d   = '0;
    rsp_to_d    = '0;
    tx_vld_d    = 1'b0;
    tx_msg_d    = tx_msg_q;
    rsp_msg_d   = rsp_msg_q;
    err_unsol_d = RX_VLD && (state_q != WAIT_RSP);
    case (state_q)
      IDLE: if (hit) begin
        state_d   = WAIT_DNE;
        gnt_d     = pick;
        ptr_d     = (pick == PW'(pNUM_REQ - 1)) ? '0 : pick + 1'b1;
        req_ack_d = pNUM_REQ'(1) << pick;
        tx_vld_d  = 1'b1;
        tx_msg_d  = REQ_MSG[pick*pTX_MSG_LEN +: pTX_MSG_LEN];
      end
      WAIT_DNE: if (TX_DNE) begin
        state_d = WAIT_RSP;
        tmr_d   = '0;
      end
      WAIT_RSP: begin
        tmr_d = tmr_q + 1'b1;
        if (RX_VLD) begin
          state_d   = IDLE;
          rsp_vld_d = pNUM_REQ'(1) << gnt_q;
          rsp_msg_d = RX_MSG;
        end else if (tmr_q == TW'(pRSP_TMO - 1)) begin
          state_d  = IDLE;
          rsp_to_d = pNUM_REQ'(1) << gnt_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge CLK_25M) begin
    if (!RST_N) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      gnt_q       <= '0;
      tmr_q       <= '0;
      req_ack_q   <= '0;
      rsp_vld_q   <= '0;
      rsp_to_q    <= '0;
      tx_vld_q    <= 1'b0;
      err_unsol_q <= 1'b0;
      tx_msg_q    <= '0;
      rsp_msg_q   <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      gnt_q       <= gnt_d;
      tmr_q       <= tmr_d;
      req_ack_q   <= req_ack_d;
      rsp_vld_q   <= rsp_vld_d;
      rsp_to_q    <= rsp_to_d;
      tx_vld_q    <= tx_vld_d;
      err_unsol_q <= err_unsol_d;
      tx_msg_q    <= tx_msg_d;
      rsp_msg_q   <= rsp_msg_d;
    end
  end
  assign REQ_ACK   = req_ack_q;
  assign RSP_VLD   = rsp_vld_q;
  assign RSP_TO    = rsp_to_q;
  assign RSP_MSG   = rsp_msg_q;
  assign TX_VLD    = tx_vld_q;
  assign TX_MSG    = tx_msg_q;
  assign ERR_UNSOL = err_unsol_q;
  assign BUSY      = (state_q != IDLE);
endmodule

// File: tb/tb_mcht_link_arb.sv
// tb_mcht_link_arb: randomized and directed checks of mcht_link_arb against a transaction-level model.
module tb_mcht_link_arb;
  logic clk = 1'b0;
  logic RST_N = 1'b0;
  logic [3:0] REQ_VLD = '0;
  logic [63:0] REQ_MSG = '0;
  logic [3:0] REQ_ACK, RSP_VLD, RSP_TO;
  logic [15:0] RSP_MSG, TX_MSG;
  logic BUSY, ERR_UNSOL, TX_VLD;
  logic TX_DNE = 1'b0;
  logic [15:0] RX_MSG = '0;
  logic RX_VLD = 1'b0;
  int n_cmp = 0, n_err = 0;
  int m_ptr = 0;
  logic [15:0] m_rsp = '0;
  logic [15:0] req_msg [4];
  mcht_link_arb #(.pNUM_REQ(4), .pTX_MSG_LEN(16), .pRX_MSG_LEN(16), .pRSP_TMO(16)) dut (
    .CLK_25M(clk), .RST_N(RST_N), .REQ_VLD(REQ_VLD), .REQ_MSG(REQ_MSG),
    .REQ_ACK(REQ_ACK), .RSP_VLD(RSP_VLD), .RSP_TO(RSP_TO), .RSP_MSG(RSP_MSG),
    .BUSY(BUSY), .ERR_UNSOL(ERR_UNSOL), .TX_VLD(TX_VLD), .TX_MSG(TX_MSG),
    .TX_DNE(TX_DNE), .RX_MSG(RX_MSG), .RX_VLD(RX_VLD)
  );
  always #20 clk = ~clk;
  task automatic tick();
    @(negedge clk);
  endtask
  task automatic pack();
    REQ_MSG = {req_msg[3], req_msg[2], req_msg[1], req_msg[0]};
  endtask
  function automatic int pick_model(input logic [3:0] v, input int p);
    for (int k = 0; k < 4; k++) if (v[(p + k) % 4]) return (p + k) % 4;
    return 0;
  endfunction
  // rsp_k: 0..15 respond after that many WAIT_RSP cycles, -1 let it time out, -2 stop inside WAIT_RSP.
  task automatic do_txn(input int dne_dly, input int rsp_k, input logic [15:0] rx, input bit unsol, output int g);
    logic [3:0] oh;
    int nwait;
    g = pick_model(REQ_VLD, m_ptr);
    oh = 4'b0001 << g;
    tick();
    n_cmp++;
    if ({REQ_ACK, TX_VLD, BUSY, RSP_VLD, RSP_TO} !== {oh, 2'b11, 8'h00}) begin
      n_err++;
      $display("FAIL grant: ack/txv/busy/rsp/to got %b/%b/%b/%b/%b want %b/1/1/0000/0000", REQ_ACK, TX_VLD, BUSY, RSP_VLD, RSP_TO, oh);
    end
    n_cmp++;
    if (TX_MSG !== req_msg[g]) begin
      n_err++;
      $display("FAIL tx_msg: got %h want %h", TX_MSG, req_msg[g]);
    end
    m_ptr = (g + 1) % 4;
    REQ_VLD[g] = 1'b0;
    for (int i = 0; i < dne_dly; i++) begin
      RX_VLD = unsol && i == 0;
      RX_MSG = 16'($urandom);
      tick();
      RX_VLD = 1'b0;
      n_cmp++;
      if ({REQ_ACK, TX_VLD, ERR_UNSOL, BUSY, TX_MSG, RSP_MSG} !== {4'b0, 1'b0, unsol && i == 0, 1'b1, req_msg[g], m_rsp}) begin
        n_err++;
        $display("FAIL dne_wait: ack/txv/err/busy/txm/rspm got %b/%b/%b/%b/%h/%h want 0000/0/%b/1/%h/%h",
                 REQ_ACK, TX_VLD, ERR_UNSOL, BUSY, TX_MSG, RSP_MSG, unsol && i == 0, req_msg[g], m_rsp);
      end
    end
    TX_DNE = 1'b1;
    tick();
    TX_DNE = 1'b0;
    if (rsp_k == -2) begin
      tick();
      tick();
      return;
    end
    nwait = (rsp_k < 0) ? 15 : rsp_k;
    for (int i = 0; i < nwait; i++) begin
      tick();
      n_cmp++;
      if ({RSP_VLD, RSP_TO, BUSY} !== 9'b000000001) begin
        n_err++;
        $display("FAIL rsp_wait: rsp/to/busy got %b/%b/%b want 0000/0000/1", RSP_VLD, RSP_TO, BUSY);
      end
    end
    if (rsp_k >= 0) begin
      RX_MSG = rx;
      RX_VLD = 1'b1;
      tick();
      RX_VLD = 1'b0;
      m_rsp = rx;
      n_cmp++;
      if ({RSP_VLD, RSP_TO, BUSY, ERR_UNSOL} !== {oh, 4'b0, 2'b00}) begin
        n_err++;
        $display("FAIL response: rsp/to/busy/err got %b/%b/%b/%b want %b/0000/0/0", RSP_VLD, RSP_TO, BUSY, ERR_UNSOL, oh);
      end
    end else begin
      tick();
      n_cmp++;
      if ({RSP_VLD, RSP_TO, BUSY} !== {4'b0, oh, 1'b0}) begin
        n_err++;
        $display("FAIL timeout: rsp/to/busy got %b/%b/%b want 0000/%b/0", RSP_VLD, RSP_TO, BUSY, oh);
      end
    end
    n_cmp++;
    if (RSP_MSG !== m_rsp) begin
      n_err++;
      $display("FAIL rsp_msg: got %h want %h", RSP_MSG, m_rsp);
    end
  endtask
  task automatic test_reset();
    REQ_VLD = '0;
    RX_VLD = 1'b0;
    TX_DNE = 1'b0;
    RST_N = 1'b0;
    tick();
    tick();
    RST_N = 1'b1;
    m_ptr = 0;
    m_rsp = '0;
    n_cmp++;
    if ({REQ_ACK, RSP_VLD, RSP_TO, TX_VLD, ERR_UNSOL, BUSY, TX_MSG, RSP_MSG} !== '0) begin
      n_err++;
      $display("FAIL reset: ack/rsp/to/txv/err/busy/txm/rspm got %b/%b/%b/%b/%b/%b/%h/%h want all zero",
               REQ_ACK, RSP_VLD, RSP_TO, TX_VLD, ERR_UNSOL, BUSY, TX_MSG, RSP_MSG);
    end
  endtask
  task automatic test_single();
    int g;
    test_reset();
    req_msg[1] = 16'hA5C3;
    pack();
    REQ_VLD = 4'b0010;
    do_txn(40, 10, 16'h1234, 1'b0, g);
  endtask
  task automatic test_round_robin();
    int g;
    test_reset();
    for (int i = 0; i < 4; i++) req_msg[i] = 16'($urandom);
    pack();
    REQ_VLD = 4'b1111;
    for (int i = 0; i < 4; i++) do_txn(1, 0, 16'($urandom), 1'b0, g);
    req_msg[0] = 16'($urandom);
    req_msg[3] = 16'($urandom);
    pack();
    REQ_VLD = 4'b1001;
    do_txn(2, 0, 16'($urandom), 1'b0, g);
    do_txn(2, 0, 16'($urandom), 1'b0, g);
  endtask
  task automatic test_timeout();
    int g;
    req_msg[2] = 16'hC0DE;
    pack();
    REQ_VLD = 4'b0100;
    do_txn(3, -1, 16'h0, 1'b0, g);
    REQ_VLD = 4'b0001;
    do_txn(2, 15, 16'h5A5A, 1'b0, g);
  endtask
  task automatic test_unsolicited();
    int g;
    REQ_VLD = '0;
    RX_MSG = 16'hDEAD;
    RX_VLD = 1'b1;
    tick();
    RX_VLD = 1'b0;
    n_cmp++;
    if ({ERR_UNSOL, BUSY, RSP_VLD, RSP_MSG} !== {2'b10, 4'b0, m_rsp}) begin
      n_err++;
      $display("FAIL unsol_idle: err/busy/rsp/rspm got %b/%b/%b/%h want 1/0/0000/%h", ERR_UNSOL, BUSY, RSP_VLD, RSP_MSG, m_rsp);
    end
    tick();
    n_cmp++;
    if (ERR_UNSOL !== 1'b0) begin
      n_err++;
      $display("FAIL unsol_pulse: err got %b want 0", ERR_UNSOL);
    end
    req_msg[3] = 16'h7E57;
    pack();
    REQ_VLD = 4'b1000;
    do_txn(3, 2, 16'hBEEF, 1'b1, g);
  endtask
  task automatic test_mid_reset();
    int g;
    req_msg[2] = 16'h1111;
    pack();
    REQ_VLD = 4'b0100;
    do_txn(2, -2, 16'h0, 1'b0, g);
    RST_N = 1'b0;
    tick();
    RST_N = 1'b1;
    m_ptr = 0;
    m_rsp = '0;
    n_cmp++;
    if ({REQ_ACK, RSP_VLD, RSP_TO, TX_VLD, ERR_UNSOL, BUSY, TX_MSG, RSP_MSG} !== '0) begin
      n_err++;
      $display("FAIL mid_reset: ack/rsp/to/txv/err/busy/txm/rspm got %b/%b/%b/%b/%b/%b/%h/%h want all zero",
               REQ_ACK, RSP_VLD, RSP_TO, TX_VLD, ERR_UNSOL, BUSY, TX_MSG, RSP_MSG);
    end
    RX_MSG = 16'h9999;
    RX_VLD = 1'b1;
    tick();
    RX_VLD = 1'b0;
    n_cmp++;
    if ({ERR_UNSOL, RSP_VLD, RSP_TO} !== 9'b100000000) begin
      n_err++;
      $display("FAIL stale_rx: err/rsp/to got %b/%b/%b want 1/0000/0000", ERR_UNSOL, RSP_VLD, RSP_TO);
    end
    for (int i = 0; i < 4; i++) req_msg[i] = 16'($urandom);
    pack();
    REQ_VLD = 4'b1111;
    do_txn(1, 1, 16'h4242, 1'b0, g);
  endtask
  task automatic test_random();
    int g;
    logic [3:0] nv;
    for (int n = 0; n < 40; n++) begin
      nv = 4'($urandom_range(1, 15));
      for (int i = 0; i < 4; i++) if (nv[i] && !REQ_VLD[i]) req_msg[i] = 16'($urandom);
      pack();
      REQ_VLD = nv;
      do_txn($urandom_range(1, 6), ($urandom_range(0, 3) == 0) ? -1 : int'($urandom_range(0, 15)),
             16'($urandom), 1'($urandom_range(0, 1)), g);
    end
    REQ_VLD = '0;
  endtask
  initial begin
    for (int i = 0; i < 4; i++) req_msg[i] = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_timeout();
    test_unsolicited();
    test_mid_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
